// File: rtl/alu_pkg.sv
// Shared constants for the EX-stage issue unit: ALU control codes, MIPS opcode/funct
// values, the decoded-instruction record and the immediate extension helper.
package alu_pkg;

    localparam logic [3:0] ALU_ADD     = 4'd0;
    localparam logic [3:0] ALU_SUB     = 4'd1;
    localparam logic [3:0] ALU_NOT     = 4'd2;
    localparam logic [3:0] ALU_SLL     = 4'd3;
    localparam logic [3:0] ALU_SRL     = 4'd4;
    localparam logic [3:0] ALU_AND     = 4'd5;
    localparam logic [3:0] ALU_OR      = 4'd6;
    localparam logic [3:0] ALU_SLT     = 4'd7;
    localparam logic [3:0] ALU_ILLEGAL = 4'hF;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_NOT  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    typedef struct packed {
        logic [3:0] alu_cnt;
        logic       use_imm;
        logic       sign_ext;
        logic       shift_rt;
        logic       is_branch;
        logic       illegal;
    } dec_t;

    function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sign_ext);
        return sign_ext ? {{16{imm[15]}}, imm} : {16'h0000, imm};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational MIPS opcode/funct decoder producing the ALU control code and operand
// steering flags. I-type decode is present only when ALU_ISSUE_IMM_EN is defined.
module alu_decode
    import alu_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_cnt_o,
    output logic       use_imm_o,
    output logic       sign_ext_o,
    output logic       shift_rt_o,
    output logic       is_branch_o,
    output logic       illegal_o
);

    always_comb begin
        alu_cnt_o   = ALU_ILLEGAL;
        use_imm_o   = 1'b0;
        sign_ext_o  = 1'b0;
        shift_rt_o  = 1'b0;
        is_branch_o = 1'b0;
        illegal_o   = 1'b0;

        case (opcode_i)
            OP_RTYPE: begin
                case (funct_i)
                    FN_ADD, FN_ADDU: alu_cnt_o = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_cnt_o = ALU_SUB;
                    FN_AND:          alu_cnt_o = ALU_AND;
                    FN_OR:           alu_cnt_o = ALU_OR;
                    FN_NOT:          alu_cnt_o = ALU_NOT;
                    FN_SLT:          alu_cnt_o = ALU_SLT;
                    FN_SLL: begin
                        alu_cnt_o  = ALU_SLL;
                        shift_rt_o = 1'b1;
                    end
                    FN_SRL: begin
                        alu_cnt_o  = ALU_SRL;
                        shift_rt_o = 1'b1;
                    end
                    default:         alu_cnt_o = ALU_ILLEGAL;
                endcase
            end
            OP_BEQ: begin
                alu_cnt_o   = ALU_SUB;
                is_branch_o = 1'b1;
            end
`ifdef ALU_ISSUE_IMM_EN
            OP_ADDI, OP_LW, OP_SW: begin
                alu_cnt_o  = ALU_ADD;
                use_imm_o  = 1'b1;
                sign_ext_o = 1'b1;
            end
            OP_SLTI: begin
                alu_cnt_o  = ALU_SLT;
                use_imm_o  = 1'b1;
                sign_ext_o = 1'b1;
            end
            OP_ANDI: begin
                alu_cnt_o = ALU_AND;
                use_imm_o = 1'b1;
            end
            OP_ORI: begin
                alu_cnt_o = ALU_OR;
                use_imm_o = 1'b1;
            end
`endif
            default: alu_cnt_o = ALU_ILLEGAL;
        endcase

        illegal_o = (alu_cnt_o == ALU_ILLEGAL);
    end

endmodule

// File: rtl/alu_issue.sv
// EX-stage issue unit: ISS register drives the external combinational ALU, RES register
// captures its result behind a valid/ready handshake. Optional I-type path: ALU_ISSUE_IMM_EN.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [DATA_W-1:0] in_rs_data,
    input  logic [DATA_W-1:0] in_rt_data,
    output logic [3:0]        alu_cnt,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_zero,
    output logic              res_branch,
    output logic              res_illegal
);

    dec_t dec;

    alu_decode u_decode (
        .opcode_i    (in_opcode),
        .funct_i     (in_funct),
        .alu_cnt_o   (dec.alu_cnt),
        .use_imm_o   (dec.use_imm),
        .sign_ext_o  (dec.sign_ext),
        .shift_rt_o  (dec.shift_rt),
        .is_branch_o (dec.is_branch),
        .illegal_o   (dec.illegal)
    );

`ifdef ALU_ISSUE_IMM_EN
    logic [DATA_W-1:0] imm_ext;
    assign imm_ext = ext_imm(in_imm, dec.sign_ext);
`else
    logic unused_imm;
    assign unused_imm = ^{in_imm, dec.use_imm, dec.sign_ext};
`endif

    logic [DATA_W-1:0] op1_sel, op2_sel;
    logic [4:0]        shamt_sel;

    // Illegal instructions present zero operands so nothing meaningful reaches the ALU.
    always_comb begin
        op1_sel   = dec.shift_rt ? in_rt_data : in_rs_data;
        op2_sel   = in_rt_data;
        shamt_sel = dec.shift_rt ? in_shamt : 5'd0;
`ifdef ALU_ISSUE_IMM_EN
        if (dec.use_imm) begin
            op2_sel = imm_ext;
        end
`endif
        if (dec.illegal) begin
            op1_sel   = '0;
            op2_sel   = '0;
            shamt_sel = 5'd0;
        end
    end

    logic              iss_vld_q, iss_vld_d;
    logic [3:0]        iss_cnt_q, iss_cnt_d;
    logic [DATA_W-1:0] iss_in1_q, iss_in1_d;
    logic [DATA_W-1:0] iss_in2_q, iss_in2_d;
    logic [4:0]        iss_shamt_q, iss_shamt_d;
    logic              iss_br_q, iss_br_d;
    logic              iss_ill_q, iss_ill_d;

    logic              res_vld_q, res_vld_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic              res_zero_q, res_zero_d;
    logic              res_br_q, res_br_d;
    logic              res_ill_q, res_ill_d;

    logic iss_accept, res_load;

    assign in_ready   = !flush && (!iss_vld_q || !res_vld_q || res_ready);
    assign iss_accept = in_valid && in_ready;
    assign res_load   = iss_vld_q && (!res_vld_q || res_ready);

    always_comb begin
        iss_vld_d   = iss_vld_q;
        iss_cnt_d   = iss_cnt_q;
        iss_in1_d   = iss_in1_q;
        iss_in2_d   = iss_in2_q;
        iss_shamt_d = iss_shamt_q;
        iss_br_d    = iss_br_q;
        iss_ill_d   = iss_ill_q;
        res_vld_d   = res_vld_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        res_br_d    = res_br_q;
        res_ill_d   = res_ill_q;

        // ISS: capture decoded instruction; ALU ports hold while this stage is stalled.
        if (iss_accept) begin
            iss_vld_d   = 1'b1;
            iss_cnt_d   = dec.alu_cnt;
            iss_in1_d   = op1_sel;
            iss_in2_d   = op2_sel;
            iss_shamt_d = shamt_sel;
            iss_br_d    = dec.is_branch;
            iss_ill_d   = dec.illegal;
        end else if (res_load) begin
            iss_vld_d = 1'b0;
        end

        // RES: the ALU's output for an illegal code is undefined and is masked here.
        if (res_load) begin
            res_vld_d  = 1'b1;
            res_data_d = iss_ill_q ? '0 : alu_result;
            res_zero_d = !iss_ill_q && alu_zero;
            res_br_d   = iss_br_q && !iss_ill_q && alu_zero;
            res_ill_d  = iss_ill_q;
        end else if (res_ready) begin
            res_vld_d = 1'b0;
        end

        if (flush) begin
            iss_vld_d = 1'b0;
            res_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_vld_q   <= 1'b0;
            iss_cnt_q   <= ALU_ADD;
            iss_in1_q   <= '0;
            iss_in2_q   <= '0;
            iss_shamt_q <= 5'd0;
            iss_br_q    <= 1'b0;
            iss_ill_q   <= 1'b0;
            res_vld_q   <= 1'b0;
            res_data_q  <= '0;
            res_zero_q  <= 1'b0;
            res_br_q    <= 1'b0;
            res_ill_q   <= 1'b0;
        end else begin
            iss_vld_q   <= iss_vld_d;
            iss_cnt_q   <= iss_cnt_d;
            iss_in1_q   <= iss_in1_d;
            iss_in2_q   <= iss_in2_d;
            iss_shamt_q <= iss_shamt_d;
            iss_br_q    <= iss_br_d;
            iss_ill_q   <= iss_ill_d;
            res_vld_q   <= res_vld_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            res_br_q    <= res_br_d;
            res_ill_q   <= res_ill_d;
        end
    end

    assign alu_cnt     = iss_vld_q ? iss_cnt_q : ALU_ADD;
    assign alu_in1     = iss_in1_q;
    assign alu_in2     = iss_in2_q;
    assign alu_shamt   = iss_shamt_q;

    assign res_valid   = res_vld_q;
    assign res_data    = res_data_q;
    assign res_zero    = res_zero_q;
    assign res_branch  = res_br_q;
    assign res_illegal = res_ill_q;

endmodule

// File: doc/alu_issue.md
# alu_issue

EX-stage issue unit that drives the combinational ALU from the opposite side of its interface. Accepts one instruction per cycle over a valid/ready handshake, decodes MIPS opcode/funct into the 4-bit ALU control code, selects and extends operands, and holds them stable on the ALU ports for one cycle. It captures `result`/`zero` into an output register with its own valid/ready handshake, and derives the branch decision. It sits between the ID/EX boundary and the memory stage.

## Interface
- `DATA_W`, 32, operand/result width (fixed at 32; any other value is unsupported)
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `flush` in 1: synchronous pipeline kill
- `in_valid` in 1; `in_ready` out 1: instruction handshake
- `in_opcode` in 6; `in_funct` in 6; `in_shamt` in 5; `in_imm` in 16
- `in_rs_data` in 32; `in_rt_data` in 32
- `alu_cnt` out 4; `alu_in1` out 32; `alu_in2` out 32; `alu_shamt` out 5: to ALU
- `alu_result` in 32; `alu_zero` in 1: from ALU, combinational
- `res_valid` out 1; `res_ready` in 1: result handshake
- `res_data` out 32; `res_zero` out 1; `res_branch` out 1; `res_illegal` out 1

## Operation
- ALU codes: 0 ADD, 1 SUB, 2 NOT, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 SLT (unsigned); 4'hF ILLEGAL.
- R-type (opcode 0x00), by funct:
  - 0x20/0x21 → ADD
  - 0x22/0x23 → SUB
  - 0x24 → AND
  - 0x25 → OR
  - 0x27 → NOT(rs)
  - 0x2A → SLT
  - 0x00 → SLL(rt)
  - 0x02 → SRL(rt)
- Operand selection:
  - `alu_in1` = rs, except SLL/SRL use rt.
  - `alu_in2` = rt for R-type and beq.
  - `alu_shamt` = `in_shamt` for shifts, otherwise 0.
- beq (0x04): SUB; `res_branch` = `alu_zero`. For all other ops `res_branch` = 0.
- I-type (only with macro): ADD for addi 0x08, lw 0x23 and sw 0x2B, using sign-extended imm. AND/OR for andi 0x0C/ori 0x0D, using zero-extended imm. SLT for slti 0x0A, using sign-extended imm. In every case `alu_in2` = extended imm.
- Any other opcode/funct:
  - `alu_cnt` = 4'hF, `alu_in1`/`alu_in2` = 0.
  - Captured `res_data` forced to 0, `res_zero` = 0, `res_illegal` = 1.
  - The ALU's undefined result is never propagated.
- Two stages:
  - ISS: issue register; drives ALU ports from registered fields.
  - RES: captures ALU outputs.
- Each stage is a single entry with its own valid bit. Stalls propagate backward with no loss or duplication.

## Timing
- Reset: `in_ready`=1, `res_valid`=0, `res_data`=0, `res_zero`=0, `res_branch`=0, `res_illegal`=0, `alu_cnt`=0, `alu_in1`/`alu_in2`=0, `alu_shamt`=0.
- Handshakes:
  - Input accepted on a rising edge with `in_valid` && `in_ready`.
  - Output transferred when `res_valid` && `res_ready`.
  - `res_*` are held stable while `res_valid` && !`res_ready`.
- Latency: accepted at edge N → ALU ports driven during cycle N+1 → `res_valid` high in cycle N+2 if RES is free.
- Throughput: 1 instruction/cycle when `res_ready` is held high.
- `in_ready` = !`flush` && (!iss_valid || !res_valid || `res_ready`). This is combinational from `res_ready`.
- RES loads when iss_valid && (!res_valid || `res_ready`). ISS loads or clears in the same edge.
- ALU ports hold their last values while ISS is stalled. When ISS is empty, `alu_cnt` is 0 (don't-care to the consumer).
- `flush`: both valid bits clear at the edge; the same-cycle input is not accepted. `flush` and `rst` together behave as `rst`.
- Reset mid-operation discards all in-flight entries.

## Configuration
- `ALU_ISSUE_IMM_EN` defined: I-type decode and the immediate extension path are compiled in.
- Undefined: every nonzero opcode except beq decodes to ILLEGAL, and `in_imm` is unused.

## Structure
- Shared package `alu_pkg`: ALU code constants, opcode and funct constants, and the ILLEGAL code.
- Sub-module `alu_decode`: purely combinational. Takes (opcode, funct) → (alu_cnt, use_imm, sign_ext, shift_rt, is_branch, illegal).
- `alu_issue` instantiates `alu_decode` on the input side and registers its outputs into ISS.

## Test plan
- Reset, then add: rs=5, rt=7, funct 0x20 → `res_valid` 2 cycles later, `res_data`=12, `res_zero`=0, `alu_cnt`=0 during the issue cycle.
- beq: rs=rt=0x1234 → `res_data`=0, `res_zero`=1, `res_branch`=1. With rt=0x1235 → `res_branch`=0.
- Shifts: SLL rt=1, shamt=4 → 16; SRL rt=0x80000000, shamt=31 → 1.
- Backpressure: stream 4 adds with `res_ready` low for 3 cycles → `in_ready` drops after 2 accepts, results arrive in order, none lost or duplicated, `res_*` held stable while stalled.
- Illegal opcode 0x3F (and 0x08 with macro undefined) → `res_illegal`=1, `res_data`=0. With macro, addi imm=0xFFFF, rs=1 → `res_data`=0.
- `flush` asserted with ISS and RES both full → `res_valid`=0 next cycle, the flushed entries never appear, and the next accepted add completes normally.
